// File: rtl/id_scoreboard.sv
// Register-dependency scoreboard for the ID stage: per-register pending-write
// counters gate issue on RAW hazards and WAW counter saturation.
module id_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_valid,
  input  logic        es_allowin,
  input  logic [4:0]  ds_src1_addr,
  input  logic        ds_src1_used,
  input  logic [4:0]  ds_src2_addr,
  input  logic        ds_src2_used,
  input  logic [4:0]  ds_dest,
  input  logic        ds_gr_we,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic        flush,
  output logic        ds_ready_go,
  output logic        sb_busy,
  output logic [31:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // r0 is hard-wired zero, so no counter exists for it.
  logic [CNT_W-1:0] pend_q [1:NREG-1];
  logic [CNT_W-1:0] pend_d [1:NREG-1];
  logic [31:0]      stall_cycles_q, stall_cycles_d;

  logic [CNT_W-1:0] src1_cnt, src2_cnt, dest_cnt, ret_cnt;
  logic             raw1, raw2, waw_full;
  logic             iss, ret;

  // NOTE: every variable written in an always_comb gets a default at the top,
  // otherwise a missed branch infers a latch.
  always_comb begin
    src1_cnt = '0;
    src2_cnt = '0;
    dest_cnt = '0;
    ret_cnt  = '0;
    for (int r = 1; r < NREG; r++) begin
      if (ds_src1_addr == 5'(r)) src1_cnt = pend_q[r];
      if (ds_src2_addr == 5'(r)) src2_cnt = pend_q[r];
      if (ds_dest      == 5'(r)) dest_cnt = pend_q[r];
      if (wb_waddr     == 5'(r)) ret_cnt  = pend_q[r];
    end
  end

  // Hazards look only at registered counters: a register retiring this cycle
  // stays blocked until the regfile has actually been written.
  always_comb begin
    raw1        = ds_src1_used && (ds_src1_addr != 5'd0) && (src1_cnt != '0);
    raw2        = ds_src2_used && (ds_src2_addr != 5'd0) && (src2_cnt != '0);
    waw_full    = ds_gr_we && (ds_dest != 5'd0) && (dest_cnt == CNT_MAX);
    ds_ready_go = !(raw1 || raw2 || waw_full);
    iss         = ds_valid && ds_ready_go && es_allowin && ds_gr_we && (ds_dest != 5'd0);
    ret         = wb_we && (wb_waddr != 5'd0);
  end

  always_comb begin
    for (int r = 1; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      if (flush) begin
        pend_d[r] = '0;
      end else begin
        if (iss && (ds_dest == 5'(r)) && !(ret && (wb_waddr == 5'(r)))) begin
          if (pend_q[r] != CNT_MAX) pend_d[r] = pend_q[r] + CNT_ONE;
        end else if (ret && (wb_waddr == 5'(r)) && !(iss && (ds_dest == 5'(r)))) begin
          if (pend_q[r] != '0) pend_d[r] = pend_q[r] - CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (ds_valid && !ds_ready_go) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // NOTE: the counters are ordinary flops read by the hazard logic every
  // cycle, so all of them are reset; a stale count would block issue forever.
  // Sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 1; r < NREG; r++) pend_q[r] <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) pend_q[r] <= pend_d[r];
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    sb_busy = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (pend_q[r] != '0) sb_busy = 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;

  // A retire with no matching outstanding write means the pipeline lost track.
  ret_on_idle_reg: assert property (@(posedge clk) disable iff (reset)
    (ret && !flush) |-> (ret_cnt != '0));

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: vector table, hand-written corner
// sequences, then random traffic against an integer-array reference model.
module tb_id_scoreboard;

  typedef struct {
    logic       valid;
    logic       allowin;
    logic [4:0] s1;
    logic       s1u;
    logic [4:0] s2;
    logic       s2u;
    logic [4:0] dest;
    logic       we;
    logic       wbwe;
    logic [4:0] wba;
    logic       flush;
  } in_t;

  typedef struct {
    in_t         i;
    logic        exp_ready;
    logic        exp_busy;
    logic [31:0] exp_stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ds_valid = 1'b0, es_allowin = 1'b0;
  logic [4:0]  ds_src1_addr = '0, ds_src2_addr = '0, ds_dest = '0, wb_waddr = '0;
  logic        ds_src1_used = 1'b0, ds_src2_used = 1'b0, ds_gr_we = 1'b0;
  logic        wb_we = 1'b0, flush = 1'b0;
  logic        ds_ready_go, sb_busy;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  id_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .ds_valid(ds_valid), .es_allowin(es_allowin),
    .ds_src1_addr(ds_src1_addr), .ds_src1_used(ds_src1_used),
    .ds_src2_addr(ds_src2_addr), .ds_src2_used(ds_src2_used),
    .ds_dest(ds_dest), .ds_gr_we(ds_gr_we),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .flush(flush),
    .ds_ready_go(ds_ready_go), .sb_busy(sb_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(int valid, int allowin, int s1, int s1u, int s2, int s2u,
                             int dest, int we, int wbwe, int wba, int fl);
    in_t v;
    v.valid = 1'(valid); v.allowin = 1'(allowin);
    v.s1 = 5'(s1); v.s1u = 1'(s1u); v.s2 = 5'(s2); v.s2u = 1'(s2u);
    v.dest = 5'(dest); v.we = 1'(we); v.wbwe = 1'(wbwe); v.wba = 5'(wba);
    v.flush = 1'(fl);
    return v;
  endfunction

  function automatic in_t idle();
    return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic in_t wr(int d);
    return mk(1, 1, 0, 0, 0, 0, d, 1, 0, 0, 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs just after the falling edge; outputs are sampled 1ns later.
  task automatic apply(input in_t v);
    @(negedge clk);
    ds_valid = v.valid;   es_allowin = v.allowin;
    ds_src1_addr = v.s1;  ds_src1_used = v.s1u;
    ds_src2_addr = v.s2;  ds_src2_used = v.s2u;
    ds_dest = v.dest;     ds_gr_we = v.we;
    wb_we = v.wbwe;       wb_waddr = v.wba;
    flush = v.flush;
    #1;
  endtask

  task automatic step(input string name, input in_t v, input logic er, input logic eb,
                      input logic [31:0] es);
    apply(v);
    check({name, ".ready"}, 32'(ds_ready_go), 32'(er));
    check({name, ".busy"},  32'(sb_busy),     32'(eb));
    check({name, ".stall"}, stall_cycles,     es);
  endtask

  task automatic do_reset();
    apply(idle());
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("reset.ready", 32'(ds_ready_go), 32'd1);
    check("reset.busy",  32'(sb_busy),     32'd0);
    check("reset.stall", stall_cycles,     32'd0);
    reset = 1'b0;
  endtask

  // Reference model: plain integer counts per register.
  int          m_pend [32];
  int unsigned m_stall;

  function automatic logic m_ready(input in_t v);
    logic h1, h2, hw;
    h1 = v.s1u && v.s1 != 0 && m_pend[v.s1] != 0;
    h2 = v.s2u && v.s2 != 0 && m_pend[v.s2] != 0;
    hw = v.we && v.dest != 0 && m_pend[v.dest] == 3;
    return !(h1 || h2 || hw);
  endfunction

  function automatic logic m_busy();
    for (int r = 0; r < 32; r++) if (m_pend[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clock(input in_t v);
    logic rdy;
    rdy = m_ready(v);
    if (v.valid && !rdy) m_stall++;
    if (v.flush) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
    end else begin
      if (v.valid && rdy && v.allowin && v.we && v.dest != 0) m_pend[v.dest]++;
      if (v.wbwe && v.wba != 0 && m_pend[v.wba] > 0) m_pend[v.wba]--;
    end
  endtask

  vec_t tbl [11];

  initial begin
    // RAW stall, r0 / unused sources, simultaneous issue+retire, allowin low.
    tbl[0]  = '{mk(1,1,1,1,2,1,4,1,0,0,0), 1'b1, 1'b0, 32'd0};
    tbl[1]  = '{mk(1,1,3,1,4,1,5,1,0,0,0), 1'b0, 1'b1, 32'd0};
    tbl[2]  = '{mk(1,1,3,1,4,1,5,1,0,0,0), 1'b0, 1'b1, 32'd1};
    tbl[3]  = '{mk(1,1,3,1,4,1,5,1,1,4,0), 1'b0, 1'b1, 32'd2};
    tbl[4]  = '{mk(1,1,3,1,4,1,5,1,0,0,0), 1'b1, 1'b0, 32'd3};
    tbl[5]  = '{mk(1,1,0,1,5,0,0,1,0,0,0), 1'b1, 1'b1, 32'd3};
    tbl[6]  = '{mk(1,1,0,1,0,1,0,0,0,0,0), 1'b1, 1'b1, 32'd3};
    tbl[7]  = '{mk(1,1,1,1,2,1,5,1,1,5,0), 1'b1, 1'b1, 32'd3};
    tbl[8]  = '{mk(0,1,0,0,0,0,0,0,1,5,0), 1'b1, 1'b1, 32'd3};
    tbl[9]  = '{mk(1,0,0,0,0,0,6,1,0,0,0), 1'b1, 1'b0, 32'd3};
    tbl[10] = '{mk(0,1,0,0,0,0,0,0,0,0,0), 1'b1, 1'b0, 32'd3};

    do_reset();
    for (int k = 0; k < 11; k++)
      step($sformatf("tbl%0d", k), tbl[k].i, tbl[k].exp_ready, tbl[k].exp_busy,
           tbl[k].exp_stall);

    // WAW cap on r6: three writers fill the counter, the fourth waits for a retire.
    do_reset();
    step("waw0", wr(6), 1'b1, 1'b0, 32'd0);
    step("waw1", wr(6), 1'b1, 1'b1, 32'd0);
    step("waw2", wr(6), 1'b1, 1'b1, 32'd0);
    step("waw3", wr(6), 1'b0, 1'b1, 32'd0);
    step("waw4", mk(1,1,0,0,0,0,6,1,1,6,0), 1'b0, 1'b1, 32'd1);
    step("waw5", wr(6), 1'b1, 1'b1, 32'd2);
    step("waw6", mk(0,1,0,0,0,0,6,1,0,0,0), 1'b0, 1'b1, 32'd2);
    step("waw7", mk(0,1,0,0,0,0,6,1,0,0,0), 1'b0, 1'b1, 32'd2);

    // Flush beats a concurrent issue to r8 and leaves stall_cycles alone.
    do_reset();
    step("fl0", wr(7), 1'b1, 1'b0, 32'd0);
    step("fl1", wr(7), 1'b1, 1'b1, 32'd0);
    step("fl2", wr(9), 1'b1, 1'b1, 32'd0);
    step("fl3", mk(1,1,0,0,9,1,0,0,0,0,0), 1'b0, 1'b1, 32'd0);
    step("fl4", mk(1,1,0,0,0,0,8,1,0,0,1), 1'b1, 1'b1, 32'd1);
    step("fl5", mk(1,1,7,1,8,1,0,0,0,0,0), 1'b1, 1'b0, 32'd1);
    step("fl6", mk(1,1,9,1,7,1,0,0,0,0,0), 1'b1, 1'b0, 32'd1);

    // Asynchronous reset between edges while a reader of r4 is stalled.
    do_reset();
    step("ar0", wr(4), 1'b1, 1'b0, 32'd0);
    step("ar1", wr(4), 1'b1, 1'b1, 32'd0);
    for (int k = 0; k < 10; k++) apply(mk(1,1,0,0,4,1,0,0,0,0,0));
    step("ar2", mk(1,1,0,0,4,1,0,0,0,0,0), 1'b0, 1'b1, 32'd10);
    #1 reset = 1'b1;
    #1;
    check("ar.mid.ready", 32'(ds_ready_go), 32'd1);
    check("ar.mid.busy",  32'(sb_busy),     32'd0);
    check("ar.mid.stall", stall_cycles,     32'd0);
    #1 reset = 1'b0;
    step("ar3", mk(1,1,0,0,4,1,0,0,0,0,0), 1'b1, 1'b0, 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
    m_stall = 0;
    for (int c = 0; c < 600; c++) begin
      in_t v;
      int  cand [$];
      v = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 12), $urandom_range(0, 1),
             $urandom_range(0, 12), $urandom_range(0, 1),
             $urandom_range(0, 12), $urandom_range(0, 3) != 0,
             0, 0, $urandom_range(0, 49) == 0);
      cand.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r] > 0) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(0, 9) < 4) begin
        v.wbwe = 1'b1;
        v.wba  = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      apply(v);
      check($sformatf("rnd%0d.ready", c), 32'(ds_ready_go), 32'(m_ready(v)));
      check($sformatf("rnd%0d.busy", c),  32'(sb_busy),     32'(m_busy()));
      check($sformatf("rnd%0d.stall", c), stall_cycles,     m_stall);
      m_clock(v);
    end

    apply(idle());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Register-dependency scoreboard and issue controller for the ID stage. It tracks, per architectural register, how many issued instructions that write that register have not yet written back. It generates `ds_ready_go` so that ID holds an instruction whose source registers are still pending. ID's `ds_allowin` / `ds_to_es_valid` handshake uses this signal in place of the constant 1; the block also counts stall cycles for performance analysis.

## Interface

Parameters:
- `NREG`, 32, number of architectural registers (r0 hard-wired zero, never tracked)
- `CNT_W`, 2, width of each per-register pending counter; max in-flight writes per register = 2^CNT_W − 1

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `ds_valid`  in  1  ID holds a valid instruction
- `es_allowin`  in  1  EXE can accept this cycle
- `ds_src1_addr`  in  5  first source register (rd for branch/store, else rk)
- `ds_src1_used`  in  1  instruction actually reads src1
- `ds_src2_addr`  in  5  second source register (rj)
- `ds_src2_used`  in  1  instruction actually reads src2
- `ds_dest`  in  5  destination register
- `ds_gr_we`  in  1  instruction writes `ds_dest`
- `wb_we`  in  1  WB write-back strobe this cycle (`wb_bus` bit 37)
- `wb_waddr`  in  5  WB destination (`wb_bus` bits 36:32)
- `flush`  in  1  all instructions in EXE/MEM/WB are cancelled this cycle
- `ds_ready_go`  out  1  ID may issue the current instruction
- `sb_busy`  out  1  at least one counter is non-zero
- `stall_cycles`  out  32  count of cycles with `ds_valid & ~ds_ready_go`

## Operation

- State: `pend[1..NREG-1]`, each CNT_W bits, plus the 32-bit `stall_cycles` register. `pend[0]` is constant 0.
- Hazard detection is combinational from registered state only:
  - `raw1 = ds_src1_used & (ds_src1_addr != 0) & (pend[ds_src1_addr] != 0)`
  - `raw2` is defined the same way for src2.
  - `waw_full = ds_gr_we & (ds_dest != 0) & (pend[ds_dest] == MAX)`
  - `ds_ready_go = ~(raw1 | raw2 | waw_full)`
- `ds_ready_go` does not depend on `ds_valid` or `es_allowin`. There is no combinational path from `wb_we`/`wb_waddr` to `ds_ready_go`. The regfile writes at the edge, so a pending register remains blocked during its retire cycle. The consumer issues the following cycle and reads the new value.
- Issue event: `iss = ds_valid & ds_ready_go & es_allowin & ds_gr_we & (ds_dest != 0)`.
- Retire event: `ret = wb_we & (wb_waddr != 0)`.
- Per-register next state for r:
  - Increment by 1 when `iss` targets r and `ret` does not.
  - Decrement by 1 when `ret` targets r and `iss` does not.
  - Hold when both events target r in the same cycle (net 0).
  - Hold when neither event targets r.
- Retire on a register whose counter is 0 is a protocol error. The counter holds at 0 (no wrap). Simulation flags it with an assertion.
- Increment is blocked at MAX by `waw_full`, so the counter never wraps.
- `flush` has priority over issue and retire: all counters clear to 0 at the next edge. `stall_cycles` is unaffected by `flush`.
- `stall_cycles` increments by 1 on every cycle with `ds_valid & ~ds_ready_go`. It wraps from 0xFFFFFFFF to 0.
- `sb_busy` is the OR of all counters, taken from registered state.

## Timing

- Reset (async, active-high) sets all `pend` to 0 and `stall_cycles` to 0. While in reset, `ds_ready_go` = 1 and `sb_busy` = 0. Reset asserted mid-operation discards all pending counts immediately, without waiting for a clock edge.
- Issue at edge N makes `pend[dest]` visible at N+1. A dependent instruction in ID at cycle N+1 sees `ds_ready_go` = 0.
- Retire at cycle M (`wb_we` high) makes the counter decrement visible at M+1. A waiting consumer gets `ds_ready_go` = 1 at cycle M+1 and issues at the end of M+1 if `es_allowin` is high.
- Back-to-back dependency through a 3-stage EXE/MEM/WB pipeline: the consumer stalls 3 cycles with no forwarding.
- When `flush` is high at cycle F: `ds_ready_go` at cycle F still reflects old state, and from F+1 all hazards are clear.
- `es_allowin` low with `ds_ready_go` high: no issue, no counter change, no stall count.

## Test plan

- RAW stall: issue `add.w r4,r1,r2` at cycle 0; next instr reads r4 via rj → `ds_ready_go` = 0 cycles 1–3; `wb_we` with `wb_waddr` = 4 at cycle 3 → `ds_ready_go` = 1 at cycle 4; `stall_cycles` = 3.
- r0 and unused sources: write r0 then read r0; src2 = r4 with `ds_src2_used` = 0 while `pend[4]` = 1 → `ds_ready_go` stays 1; `pend[0]` never changes.
- Simultaneous issue/retire on r5 with `pend[5]` = 1 → `pend[5]` stays 1; `sb_busy` stays 1.
- WAW cap: three issues writing r6 (`pend[6]` = 3); fourth writer to r6 → `ds_ready_go` = 0 until a retire of r6, then issues and `pend[6]` returns to 3.
- Flush: `pend[7]` = 2, `pend[9]` = 1, assert `flush` while issuing a write to r8 → next cycle all counters 0, `sb_busy` = 0, reader of r7 gets `ds_ready_go` = 1.
- Async reset mid-stall: `pend[4]` = 2 and `stall_cycles` = 10, raise `reset` between edges → counters and `stall_cycles` read 0 before the next edge; `ds_ready_go` = 1.
